// File: rtl/gshare_bht_if.sv
// Frontend <-> branch history table signal bundle.
// master = frontend (drives fetch/resolve info), slave = BHT (returns predictions).
interface gshare_bht_if #(
    parameter int unsigned VLEN            = 64,
    parameter int unsigned INSTR_PER_FETCH = 2,
    parameter int unsigned HIST_BITS       = 8
);
    logic                       flush_i;
    logic                       debug_mode_i;
    logic [VLEN-1:0]            vpc_i;
    logic                       spec_valid_i;
    logic                       spec_taken_i;
    logic                       upd_valid_i;
    logic [VLEN-1:0]            upd_pc_i;
    logic                       upd_taken_i;
    logic                       upd_mispredict_i;
    logic [HIST_BITS-1:0]       upd_hist_i;
    logic [INSTR_PER_FETCH-1:0] pred_valid_o;
    logic [INSTR_PER_FETCH-1:0] pred_taken_o;
    logic [HIST_BITS-1:0]       hist_o;
    logic                       init_busy_o;

    modport master (
        output flush_i, debug_mode_i, vpc_i, spec_valid_i, spec_taken_i,
               upd_valid_i, upd_pc_i, upd_taken_i, upd_mispredict_i, upd_hist_i,
        input  pred_valid_o, pred_taken_o, hist_o, init_busy_o
    );

    modport slave (
        input  flush_i, debug_mode_i, vpc_i, spec_valid_i, spec_taken_i,
               upd_valid_i, upd_pc_i, upd_taken_i, upd_mispredict_i, upd_hist_i,
        output pred_valid_o, pred_taken_o, hist_o, init_busy_o
    );
endinterface

// File: rtl/gshare_bht.sv
// Branch history table of saturating counters with a speculative global history register.
// Define BHT_GSHARE_EN for gshare indexing (PC row bits XOR history); otherwise bimodal indexing.
module gshare_bht #(
    parameter int unsigned NR_ENTRIES      = 1024,
    parameter int unsigned INSTR_PER_FETCH = 2,
    parameter int unsigned HIST_BITS       = 8,
    parameter int unsigned CTR_BITS        = 2,
    parameter int unsigned VLEN            = 64
) (
    input logic         clk_i,
    input logic         rst_ni,
    gshare_bht_if.slave bus
);
    localparam int unsigned NR_ROWS   = NR_ENTRIES / INSTR_PER_FETCH;
    localparam int unsigned ROW_BITS  = $clog2(NR_ROWS);
    localparam int unsigned LANE_BITS = $clog2(INSTR_PER_FETCH);
    localparam int unsigned LANE_W    = (LANE_BITS > 0) ? LANE_BITS : 1;
    localparam int unsigned OFFSET    = 1;
    localparam int unsigned IDX_LSB   = OFFSET + LANE_BITS;

    localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(NR_ROWS - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

    typedef enum logic {
        SWEEP,
        IDLE
    } state_e;

    typedef struct packed {
        logic                valid;
        logic [CTR_BITS-1:0] ctr;
    } entry_t;

    // Swept entries start invalid and weakly taken.
    localparam entry_t INIT_ENTRY = '{valid: 1'b0, ctr: CTR_BITS'(1) << (CTR_BITS - 1)};

    state_e                     state_q, state_d;
    logic [ROW_BITS-1:0]        row_cnt_q, row_cnt_d;
    logic [HIST_BITS-1:0]       ghr_q, ghr_d;
    entry_t                     tbl_q [NR_ROWS][INSTR_PER_FETCH];

    logic [ROW_BITS-1:0]        pred_row;
    logic [ROW_BITS-1:0]        upd_row;
    logic [LANE_W-1:0]          upd_lane;
    logic                       upd_en;
    entry_t                     upd_old;
    entry_t                     upd_new;
    logic [ROW_BITS-1:0]        wr_row;
    logic [INSTR_PER_FETCH-1:0] wr_mask;
    entry_t                     wr_entry;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.vpc_i[IDX_LSB-1:0], bus.vpc_i[VLEN-1:IDX_LSB+ROW_BITS],
                              bus.upd_pc_i[OFFSET-1:0], bus.upd_pc_i[VLEN-1:IDX_LSB+ROW_BITS]};

    // Row index: updates use the history snapshot, never the live GHR.
    always_comb begin
        pred_row = bus.vpc_i[IDX_LSB +: ROW_BITS];
        upd_row  = bus.upd_pc_i[IDX_LSB +: ROW_BITS];
`ifdef BHT_GSHARE_EN
        pred_row = pred_row ^ ROW_BITS'(ghr_q);
        upd_row  = upd_row ^ ROW_BITS'(bus.upd_hist_i);
`else
        pred_row = pred_row;
        upd_row  = upd_row;
`endif
        upd_lane = (LANE_BITS > 0) ? bus.upd_pc_i[OFFSET +: LANE_W] : '0;
    end

    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        upd_old = tbl_q[upd_row][upd_lane];
        upd_en  = bus.upd_valid_i && !bus.debug_mode_i && (state_q == IDLE);
        upd_new = '{valid: 1'b1, ctr: upd_old.ctr};
        if (bus.upd_taken_i) begin
            if (upd_old.ctr != CTR_MAX) upd_new.ctr = upd_old.ctr + CTR_BITS'(1);
        end else begin
            if (upd_old.ctr != '0) upd_new.ctr = upd_old.ctr - CTR_BITS'(1);
        end
    end

    // Single write port shared by the sweep (whole row) and updates (one lane).
    always_comb begin
        wr_row   = row_cnt_q;
        wr_mask  = '1;
        wr_entry = INIT_ENTRY;
        if (state_q == IDLE) begin
            wr_row            = upd_row;
            wr_entry          = upd_new;
            wr_mask           = '0;
            wr_mask[upd_lane] = upd_en;
        end
    end

    // NOTE: table storage is deliberately not reset; the sweep initialises it after reset.
    always_ff @(posedge clk_i) begin
        for (int l = 0; l < INSTR_PER_FETCH; l++) begin
            if (wr_mask[l]) tbl_q[wr_row][l] <= wr_entry;
        end
    end

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= SWEEP;
            row_cnt_q <= '0;
            ghr_q     <= '0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            ghr_q     <= ghr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        ghr_d     = ghr_q;
        unique case (state_q)
            SWEEP: begin
                row_cnt_d = row_cnt_q + ROW_BITS'(1);
                if (row_cnt_q == LAST_ROW) state_d = IDLE;
            end
            IDLE: begin
                if (!bus.debug_mode_i) begin
                    if (bus.upd_valid_i && bus.upd_mispredict_i) begin
                        ghr_d = {bus.upd_hist_i[HIST_BITS-2:0], bus.upd_taken_i};
                    end else if (bus.spec_valid_i) begin
                        ghr_d = {ghr_q[HIST_BITS-2:0], bus.spec_taken_i};
                    end
                end
            end
            default: ;
        endcase
        if (bus.flush_i) begin
            state_d   = SWEEP;
            row_cnt_d = '0;
            ghr_d     = '0;
        end
    end

    always_comb begin
        bus.init_busy_o  = (state_q == SWEEP);
        bus.hist_o       = ghr_q;
        bus.pred_valid_o = '0;
        bus.pred_taken_o = '0;
        for (int l = 0; l < INSTR_PER_FETCH; l++) begin
            bus.pred_valid_o[l] = tbl_q[pred_row][l].valid && (state_q == IDLE);
            bus.pred_taken_o[l] = tbl_q[pred_row][l].ctr[CTR_BITS-1];
        end
    end
endmodule

// File: tb/tb_gshare_bht.sv
// Self-checking bench for gshare_bht: directed scenarios plus randomized traffic
// against a behavioural table/history model (16 counters, 2 lanes, 3-bit history).
module tb_gshare_bht;
    localparam int unsigned NR_ENTRIES = 16;
    localparam int unsigned IPF        = 2;
    localparam int unsigned HB         = 3;
    localparam int unsigned CB         = 2;
    localparam int unsigned VLEN       = 64;
    localparam int          NR_ROWS    = 8;
`ifdef BHT_GSHARE_EN
    localparam bit GSHARE = 1'b1;
`else
    localparam bit GSHARE = 1'b0;
`endif

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    int   total  = 0;
    int   bad    = 0;

    gshare_bht_if #(.VLEN(VLEN), .INSTR_PER_FETCH(IPF), .HIST_BITS(HB)) bus ();

    gshare_bht #(
        .NR_ENTRIES(NR_ENTRIES), .INSTR_PER_FETCH(IPF), .HIST_BITS(HB),
        .CTR_BITS(CB), .VLEN(VLEN)
    ) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural model: plain counters per (row, lane), history as an integer.
    int m_valid [NR_ROWS][IPF];
    int m_ctr   [NR_ROWS][IPF];
    int m_ghr;
    int m_busy_left;

    function automatic int m_row(input logic [VLEN-1:0] pc, input int hist);
        int r;
        r = int'((pc >> 2) & 64'd7);
        if (GSHARE) r = r ^ (hist & 7);
        return r;
    endfunction

    function automatic int m_lane(input logic [VLEN-1:0] pc);
        return int'((pc >> 1) & 64'd1);
    endfunction

    task automatic model_clock();
        bit busy;
        int r;
        int l;
        busy = (m_busy_left > 0);
        if (bus.upd_valid_i && !bus.debug_mode_i && !busy) begin
            r = m_row(bus.upd_pc_i, int'(bus.upd_hist_i));
            l = m_lane(bus.upd_pc_i);
            m_valid[r][l] = 1;
            if (bus.upd_taken_i) m_ctr[r][l] = (m_ctr[r][l] < 3) ? m_ctr[r][l] + 1 : 3;
            else                 m_ctr[r][l] = (m_ctr[r][l] > 0) ? m_ctr[r][l] - 1 : 0;
        end
        if (bus.flush_i) begin
            m_ghr       = 0;
            m_busy_left = NR_ROWS;
        end else begin
            if (!bus.debug_mode_i && !busy) begin
                if (bus.upd_valid_i && bus.upd_mispredict_i)
                    m_ghr = (int'(bus.upd_hist_i) * 2 + int'(bus.upd_taken_i)) % 8;
                else if (bus.spec_valid_i)
                    m_ghr = (m_ghr * 2 + int'(bus.spec_taken_i)) % 8;
            end
            if (busy) begin
                m_busy_left--;
                if (m_busy_left == 0) begin
                    for (int i = 0; i < NR_ROWS; i++)
                        for (int j = 0; j < IPF; j++) begin
                            m_valid[i][j] = 0;
                            m_ctr[i][j]   = 2;
                        end
                end
            end
        end
    endtask

    task automatic tick();
        model_clock();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        bus.flush_i          = 1'b0;
        bus.debug_mode_i     = 1'b0;
        bus.vpc_i            = '0;
        bus.spec_valid_i     = 1'b0;
        bus.spec_taken_i     = 1'b0;
        bus.upd_valid_i      = 1'b0;
        bus.upd_pc_i         = '0;
        bus.upd_taken_i      = 1'b0;
        bus.upd_mispredict_i = 1'b0;
        bus.upd_hist_i       = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_ni      = 1'b1;
        m_ghr       = 0;
        m_busy_left = NR_ROWS;
        for (int c = 0; c < NR_ROWS; c++) begin
            #2;
            total++;
            if (bus.init_busy_o !== 1'b1) begin
                bad++;
                $display("FAIL reset_busy cycle %0d: got %b expected 1", c, bus.init_busy_o);
            end
            total++;
            if (bus.pred_valid_o !== 2'b00) begin
                bad++;
                $display("FAIL reset_pred_valid cycle %0d: got %b expected 00", c, bus.pred_valid_o);
            end
            tick();
        end
        bus.vpc_i = 64'h10;
        #2;
        total++;
        if (bus.init_busy_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_busy_end: got %b expected 0", bus.init_busy_o);
        end
        total++;
        if (bus.hist_o !== 3'b000) begin
            bad++;
            $display("FAIL reset_hist: got %b expected 000", bus.hist_o);
        end
        total++;
        if (bus.pred_valid_o !== 2'b00 || bus.pred_taken_o !== 2'b11) begin
            bad++;
            $display("FAIL reset_pred: got valid=%b taken=%b expected valid=00 taken=11",
                     bus.pred_valid_o, bus.pred_taken_o);
        end
        tick();
    endtask

    task automatic test_decrement();
        bus.vpc_i       = 64'h10;
        bus.upd_valid_i = 1'b1;
        bus.upd_pc_i    = 64'h10;
        bus.upd_hist_i  = 3'b000;
        bus.upd_taken_i = 1'b0;
        #2;
        total++;
        if (bus.pred_valid_o[0] !== 1'b0 || bus.pred_taken_o[0] !== 1'b1) begin
            bad++;
            $display("FAIL dec_same_cycle_old: got valid=%b taken=%b expected valid=0 taken=1",
                     bus.pred_valid_o[0], bus.pred_taken_o[0]);
        end
        tick();
        #2;
        total++;
        if (bus.pred_valid_o[0] !== 1'b1 || bus.pred_taken_o[0] !== 1'b0) begin
            bad++;
            $display("FAIL dec_first: got valid=%b taken=%b expected valid=1 taken=0",
                     bus.pred_valid_o[0], bus.pred_taken_o[0]);
        end
        tick();
        bus.upd_valid_i = 1'b0;
        #2;
        total++;
        if (bus.pred_valid_o !== 2'b01 || bus.pred_taken_o[0] !== 1'b0) begin
            bad++;
            $display("FAIL dec_result: got valid=%b taken0=%b expected valid=01 taken0=0",
                     bus.pred_valid_o, bus.pred_taken_o[0]);
        end
        total++;
        if (bus.hist_o !== 3'b000) begin
            bad++;
            $display("FAIL dec_hist: got %b expected 000", bus.hist_o);
        end
    endtask

    task automatic test_saturation();
        bus.vpc_i       = 64'h10;
        bus.upd_valid_i = 1'b1;
        bus.upd_pc_i    = 64'h10;
        bus.upd_hist_i  = 3'b000;
        bus.upd_taken_i = 1'b1;
        repeat (4) tick();
        bus.upd_valid_i = 1'b0;
        #2;
        total++;
        if (bus.pred_taken_o[0] !== 1'b1) begin
            bad++;
            $display("FAIL sat_high: got taken=%b expected 1", bus.pred_taken_o[0]);
        end
        bus.upd_valid_i = 1'b1;
        bus.upd_taken_i = 1'b0;
        tick();
        bus.upd_valid_i = 1'b0;
        #2;
        total++;
        if (bus.pred_taken_o[0] !== 1'b1) begin
            bad++;
            $display("FAIL sat_one_down: got taken=%b expected 1", bus.pred_taken_o[0]);
        end
        bus.upd_valid_i = 1'b1;
        tick();
        bus.upd_valid_i = 1'b0;
        #2;
        total++;
        if (bus.pred_taken_o[0] !== 1'b0) begin
            bad++;
            $display("FAIL sat_two_down: got taken=%b expected 0", bus.pred_taken_o[0]);
        end
    endtask

    task automatic test_ghr();
        bit tk [3] = '{1'b1, 1'b1, 1'b0};
        bus.spec_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.spec_taken_i = tk[i];
            tick();
        end
        bus.spec_valid_i = 1'b0;
        #2;
        total++;
        if (bus.hist_o !== 3'b110) begin
            bad++;
            $display("FAIL ghr_shift: got %b expected 110", bus.hist_o);
        end
        bus.spec_valid_i     = 1'b1;
        bus.spec_taken_i     = 1'b0;
        bus.upd_valid_i      = 1'b1;
        bus.upd_mispredict_i = 1'b1;
        bus.upd_hist_i       = 3'b101;
        bus.upd_taken_i      = 1'b1;
        bus.upd_pc_i         = 64'h06;
        tick();
        clear_inputs();
        #2;
        total++;
        if (bus.hist_o !== 3'b011) begin
            bad++;
            $display("FAIL ghr_repair: got %b expected 011", bus.hist_o);
        end
    endtask

    task automatic test_blocked();
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i          = 1'b0;
        bus.vpc_i            = 64'h10;
        bus.spec_valid_i     = 1'b1;
        bus.spec_taken_i     = 1'b1;
        bus.upd_valid_i      = 1'b1;
        bus.upd_pc_i         = 64'h10;
        bus.upd_taken_i      = 1'b1;
        bus.upd_mispredict_i = 1'b1;
        bus.upd_hist_i       = 3'b111;
        for (int c = 0; c < 5; c++) begin
            #2;
            total++;
            if (bus.init_busy_o !== 1'b1) begin
                bad++;
                $display("FAIL flush_busy cycle %0d: got %b expected 1", c, bus.init_busy_o);
            end
            tick();
        end
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        for (int c = 0; c < NR_ROWS; c++) begin
            #2;
            total++;
            if (bus.init_busy_o !== 1'b1 || bus.hist_o !== 3'b000) begin
                bad++;
                $display("FAIL reflush_busy cycle %0d: got busy=%b hist=%b expected busy=1 hist=000",
                         c, bus.init_busy_o, bus.hist_o);
            end
            tick();
        end
        clear_inputs();
        bus.vpc_i = 64'h10;
        #2;
        total++;
        if (bus.init_busy_o !== 1'b0 || bus.pred_valid_o !== 2'b00 || bus.hist_o !== 3'b000) begin
            bad++;
            $display("FAIL sweep_ignored: got busy=%b valid=%b hist=%b expected busy=0 valid=00 hist=000",
                     bus.init_busy_o, bus.pred_valid_o, bus.hist_o);
        end
        bus.debug_mode_i     = 1'b1;
        bus.upd_valid_i      = 1'b1;
        bus.upd_pc_i         = 64'h10;
        bus.upd_taken_i      = 1'b1;
        bus.upd_mispredict_i = 1'b1;
        bus.upd_hist_i       = 3'b011;
        bus.spec_valid_i     = 1'b1;
        bus.spec_taken_i     = 1'b1;
        repeat (2) tick();
        clear_inputs();
        bus.vpc_i = 64'h10;
        #2;
        total++;
        if (bus.hist_o !== 3'b000 || bus.pred_valid_o !== 2'b00 || bus.pred_taken_o !== 2'b11) begin
            bad++;
            $display("FAIL debug_block: got hist=%b valid=%b taken=%b expected hist=000 valid=00 taken=11",
                     bus.hist_o, bus.pred_valid_o, bus.pred_taken_o);
        end
    endtask

    task automatic test_alias();
        logic exp_row0;
        logic exp_row4;
        exp_row0 = GSHARE ? 1'b1 : 1'b0;
        exp_row4 = GSHARE ? 1'b0 : 1'b1;
        bus.upd_valid_i = 1'b1;
        bus.upd_pc_i    = 64'h10;
        bus.upd_hist_i  = 3'b100;
        bus.upd_taken_i = 1'b0;
        tick();
        clear_inputs();
        bus.vpc_i = 64'h00;
        #2;
        total++;
        if (bus.pred_valid_o[0] !== exp_row0) begin
            bad++;
            $display("FAIL alias_row0: got %b expected %b", bus.pred_valid_o[0], exp_row0);
        end
        bus.vpc_i = 64'h10;
        #2;
        total++;
        if (bus.pred_valid_o[0] !== exp_row4) begin
            bad++;
            $display("FAIL alias_row4: got %b expected %b", bus.pred_valid_o[0], exp_row4);
        end
    endtask

    task automatic test_random();
        int r;
        bit busy;
        logic exp_v;
        logic exp_t;
        for (int n = 0; n < 400; n++) begin
            bus.flush_i          = ($urandom_range(0, 39) == 0);
            bus.debug_mode_i     = ($urandom_range(0, 7) == 0);
            bus.vpc_i            = {$urandom, $urandom};
            bus.spec_valid_i     = 1'($urandom_range(0, 1));
            bus.spec_taken_i     = 1'($urandom_range(0, 1));
            bus.upd_valid_i      = 1'($urandom_range(0, 1));
            bus.upd_pc_i         = {$urandom, $urandom};
            bus.upd_taken_i      = 1'($urandom_range(0, 1));
            bus.upd_mispredict_i = ($urandom_range(0, 3) == 0);
            bus.upd_hist_i       = 3'($urandom_range(0, 7));
            #2;
            busy = (m_busy_left > 0);
            total++;
            if (bus.init_busy_o !== busy || bus.hist_o !== 3'(m_ghr)) begin
                bad++;
                $display("FAIL rand_state step %0d: got busy=%b hist=%b expected busy=%b hist=%b",
                         n, bus.init_busy_o, bus.hist_o, busy, 3'(m_ghr));
            end
            r = m_row(bus.vpc_i, m_ghr);
            for (int l = 0; l < IPF; l++) begin
                exp_v = busy ? 1'b0 : (m_valid[r][l] != 0);
                exp_t = (m_ctr[r][l] >= 2);
                total++;
                if (bus.pred_valid_o[l] !== exp_v || (!busy && bus.pred_taken_o[l] !== exp_t)) begin
                    bad++;
                    $display("FAIL rand_pred step %0d lane %0d: got valid=%b taken=%b expected valid=%b taken=%b",
                             n, l, bus.pred_valid_o[l], bus.pred_taken_o[l], exp_v, exp_t);
                end
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_decrement();
        test_saturation();
        test_ghr();
        test_blocked();
        test_alias();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/gshare_bht.md
# gshare_bht

Parametrised branch history table with global-history (gshare) indexing. It replaces the single-cycle-clear bimodal table in the frontend. Its state is:
- a speculative global history register (GHR), shifted on every fetch-time conditional-branch prediction and repaired on mispredict;
- a table of `NR_ROWS × INSTR_PER_FETCH` saturating counters of configurable width;
- a sequential sweep FSM that initialises the table after reset or flush.

It sits beside the BTB in the frontend and feeds `INSTR_PER_FETCH` predictions per cycle to the instruction-realign/predecode stage.

## Interface
Parameters:
- `NR_ENTRIES`, 1024: total counters; power of two.
- `INSTR_PER_FETCH`, 2: lanes per fetch; power of two.
- `HIST_BITS`, 8: GHR length; 2 ≤ `HIST_BITS` ≤ `ROW_BITS`.
- `CTR_BITS`, 2: counter width; ≥ 2.
- `VLEN`, 64: PC width.

Derived values:
- `NR_ROWS = NR_ENTRIES/INSTR_PER_FETCH`
- `ROW_BITS = clog2(NR_ROWS)`
- `LANE_BITS = clog2(INSTR_PER_FETCH)`
- `OFFSET = 1`

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `flush_i` in 1: restart table initialisation.
- `debug_mode_i` in 1: blocks table updates and GHR changes.
- `vpc_i` in VLEN: fetch PC.
- `spec_valid_i` in 1: frontend predicted a conditional branch this cycle.
- `spec_taken_i` in 1: direction of that prediction.
- `upd_valid_i` in 1: resolved conditional branch.
- `upd_pc_i` in VLEN: its PC.
- `upd_taken_i` in 1: resolved direction.
- `upd_mispredict_i` in 1: direction was mispredicted.
- `upd_hist_i` in HIST_BITS: GHR snapshot taken when the branch was predicted.
- `pred_valid_o` out INSTR_PER_FETCH: per-lane entry valid.
- `pred_taken_o` out INSTR_PER_FETCH: per-lane counter MSB.
- `hist_o` out HIST_BITS: current GHR, to be snapshotted by the frontend.
- `init_busy_o` out 1: sweep in progress.

## Operation
- **Index:** `row = pc[OFFSET+LANE_BITS +: ROW_BITS] ^ zext(hist)`.
  - Predictions use `vpc_i` and the GHR.
  - Updates use `upd_pc_i` and `upd_hist_i`, never the live GHR.
  - Update lane = `upd_pc_i[OFFSET +: LANE_BITS]`.
- **Prediction:** combinational read of registered state. For lane i, `pred_valid_o[i]` = entry valid and `pred_taken_o[i]` = counter MSB.
- **Update:** applies when `upd_valid_i && !debug_mode_i && !init_busy_o`.
  - Set entry valid = 1.
  - Counter +1 if taken, −1 if not taken, saturating at 0 and at 2^CTR_BITS−1.
  - Dropped updates leave no trace.
- **GHR:** GHR changes are blocked when `debug_mode_i` is high or while sweeping. Priority, highest first:
  - Flush/reset sets GHR = 0.
  - Repair: `upd_valid_i && upd_mispredict_i` sets GHR = `{upd_hist_i[HIST_BITS-2:0], upd_taken_i}`. Any `spec_valid_i` in the same cycle is discarded.
  - Speculative shift: `spec_valid_i` sets GHR = `{GHR[HIST_BITS-2:0], spec_taken_i}`.
- **Init FSM:** states `SWEEP` and `IDLE`.
  - In `SWEEP`, each cycle writes every lane of row `row_cnt` to valid = 0 and counter = weakly taken (MSB 1, other bits 0), then increments `row_cnt`.
  - When the write to row `NR_ROWS-1` completes, the FSM moves to `IDLE`.
  - `flush_i` in any state goes to `SWEEP` with `row_cnt` = 0 and GHR = 0. A flush mid-sweep restarts from row 0.
  - While sweeping: `init_busy_o` = 1, `pred_valid_o` forced to 0, updates and GHR changes ignored.
- **Reset values:** state `SWEEP`, `row_cnt` = 0, GHR = 0, `hist_o` = 0, `init_busy_o` = 1, `pred_valid_o` = 0. Table storage has no reset; the sweep initialises it.

## Timing
- Prediction latency: 0 cycles, combinational from `vpc_i` and registered state.
- Update written at the next rising edge. A same-cycle prediction of the same entry returns the old value.
- GHR change visible on `hist_o` the cycle after the triggering input.
- `init_busy_o` is 1 for exactly `NR_ROWS` cycles after reset release or after the last `flush_i` cycle. It is 0 in the first cycle the FSM is in `IDLE`.

## Configuration
- `BHT_GSHARE_EN` defined: index XORs in the history, as described in Operation.
- `BHT_GSHARE_EN` undefined: bimodal indexing, `row = pc[OFFSET+LANE_BITS +: ROW_BITS]`.
  - `upd_hist_i` is ignored for indexing.
  - GHR, repair and `hist_o` behave identically in both builds.

## Test plan
All scenarios use `NR_ENTRIES=16`, `INSTR_PER_FETCH=2`, `HIST_BITS=3`, `CTR_BITS=2`. Unless stated, the build has `BHT_GSHARE_EN` defined.
- **Reset:** release reset → `init_busy_o` = 1 for 8 cycles, `pred_valid_o` = 00, then `init_busy_o` = 0. Then `vpc_i` = 0x10 with GHR = 0 → valid = 0, taken = 1.
- **Decrement:** two not-taken updates, `upd_pc_i` = 0x10, `upd_hist_i` = 0 → counter 10→01→00. `vpc_i` = 0x10 → lane 0 valid = 1, taken = 0.
- **Saturation:** four taken updates to the same entry → counter saturates at 11, taken = 1. One not-taken update → counter 10, taken still 1.
- **GHR shift and repair:** `spec_valid_i` pulses with taken 1, 1, 0 → `hist_o` = 110. Then `spec_valid_i` = 1 concurrent with a mispredict repair (`upd_hist_i` = 101, `upd_taken_i` = 1) → `hist_o` = 011.
- **Aliasing:** update `upd_pc_i` = 0x10 with `upd_hist_i` = 100, not taken.
  - With `BHT_GSHARE_EN`: lands in row 0, so `vpc_i` = 0x00 with GHR = 0 shows lane 0 valid = 1.
  - Without `BHT_GSHARE_EN`: lands in row 4, so the same prediction shows valid = 0.
- **Blocked inputs:** `flush_i` at sweep cycle 5 → `init_busy_o` stays 1 for 8 further cycles. `debug_mode_i` = 1 with `upd_valid_i` → table and GHR unchanged.
